// File: rtl/button_event_if.sv
// Button event bus: debounced button level in, press/release/repeat pulses and held level out.
// release/repeat are reserved words, so those pulses carry an _evt suffix.
interface button_event_if;
  logic btn;
  logic press;
  logic release_evt;
  logic repeat_evt;
  logic held;

  modport master (
    output btn,
    input  press,
    input  release_evt,
    input  repeat_evt,
    input  held
  );

  modport slave (
    input  btn,
    output press,
    output release_evt,
    output repeat_evt,
    output held
  );
endinterface

// File: rtl/button_event.sv
// Button event generator: press/release pulses, held level and optional auto-repeat.
// Auto-repeat (REPEATING state and its counter) exists only when BUTTON_EVENT_REPEAT_EN is defined.
module button_event #(
   parameter int HOLD_CYCLES   = 25000000,
   parameter int REPEAT_CYCLES = 5000000
) (
   input logic          clk,
   input logic          rst,
   button_event_if.slave bus
);

   if (HOLD_CYCLES < 2 || REPEAT_CYCLES < 2) begin : g_param_check
      $error("button_event: HOLD_CYCLES and REPEAT_CYCLES must be at least 2");
   end

`ifdef BUTTON_EVENT_REPEAT_EN
   typedef enum logic [1:0] {IDLE, HOLD_WAIT, REPEATING} state_t;

   localparam int MAX_LIMIT = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int CNT_W     = $clog2(longint'(MAX_LIMIT) + 1);
   // Counter value seen in the cycle just before a pulse is due.
   localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(HOLD_CYCLES - 1);
   localparam logic [CNT_W-1:0] REPEAT_LAST = CNT_W'(REPEAT_CYCLES - 1);

   logic [CNT_W-1:0] cnt;
   logic             repeat_r;
`else
   typedef enum logic {IDLE, HOLD_WAIT} state_t;
`endif

   state_t state;
   logic   btn_q;
   logic   press_r;
   logic   release_r;
   logic   held_r;

   // NOTE: all state and outputs use <= so every branch sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         btn_q     <= 1'b0;
         press_r   <= 1'b0;
         release_r <= 1'b0;
         held_r    <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
         cnt       <= '0;
         repeat_r  <= 1'b0;
`endif
      end else begin
         btn_q     <= bus.btn;
         press_r   <= 1'b0;
         release_r <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
         repeat_r  <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (bus.btn && !btn_q) begin
                  state   <= HOLD_WAIT;
                  press_r <= 1'b1;
                  held_r  <= 1'b1;
`ifdef BUTTON_EVENT_REPEAT_EN
                  cnt     <= '0;
`endif
               end
            end
            HOLD_WAIT: begin
               // Release is tested first so it always wins over a due repeat.
               if (!bus.btn) begin
                  state     <= IDLE;
                  release_r <= 1'b1;
                  held_r    <= 1'b0;
`ifdef BUTTON_EVENT_REPEAT_EN
                  cnt       <= '0;
               end else if (cnt == HOLD_LAST) begin
                  state    <= REPEATING;
                  repeat_r <= 1'b1;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
`endif
               end
            end
`ifdef BUTTON_EVENT_REPEAT_EN
            REPEATING: begin
               if (!bus.btn) begin
                  state     <= IDLE;
                  release_r <= 1'b1;
                  held_r    <= 1'b0;
                  cnt       <= '0;
               end else if (cnt == REPEAT_LAST) begin
                  repeat_r <= 1'b1;
                  cnt      <= '0;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
`endif
            default: state <= IDLE;
         endcase
      end
   end

   assign bus.press       = press_r;
   assign bus.release_evt = release_r;
   assign bus.held        = held_r;
`ifdef BUTTON_EVENT_REPEAT_EN
   assign bus.repeat_evt  = repeat_r;
`else
   assign bus.repeat_evt  = 1'b0;
`endif

endmodule

// File: tb/tb_button_event.sv
// Self-checking bench for button_event: directed scenarios plus random btn traffic
// compared against an age-since-press reference model.
module tb_button_event;
   localparam int H = 10;
   localparam int R = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   button_event_if bus ();

   button_event #(.HOLD_CYCLES(H), .REPEAT_CYCLES(R)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model: pressed flag, previous sample, and edge index of the press.
   bit       m_pressed = 1'b0;
   bit       m_prev    = 1'b0;
   int       m_edge    = 0;
   int       m_p       = 0;
   logic [3:0] exp_o   = 4'b0000;   // {press, release, repeat, held}

   function automatic bit repeat_due(input int age);
`ifdef BUTTON_EVENT_REPEAT_EN
      return (age >= H) && (((age - H) % R) == 0);
`else
      return 1'b0;
`endif
   endfunction

   function automatic logic [3:0] obs();
      return {bus.press, bus.release_evt, bus.repeat_evt, bus.held};
   endfunction

   // Drive one cycle of stimulus, advance the model, settle for sampling.
   task automatic step(input logic b, input logic r);
      bit p, rl, rp;
      @(negedge clk);
      bus.btn = b;
      rst     = r;
      @(posedge clk);
      p = 1'b0; rl = 1'b0; rp = 1'b0;
      if (r) begin
         m_pressed = 1'b0;
         m_prev    = 1'b0;
      end else begin
         if (!m_pressed) begin
            if (b && !m_prev) begin
               p = 1'b1; m_pressed = 1'b1; m_p = m_edge;
            end
         end else if (!b) begin
            rl = 1'b1; m_pressed = 1'b0;
         end else begin
            rp = repeat_due(m_edge - m_p);
         end
         m_prev = b;
      end
      exp_o = {p, rl, rp, m_pressed};
      m_edge++;
      #1;
   endtask

   task automatic test_reset();
      for (int i = 0; i < 3; i++) begin
         step(logic'(i == 2), 1'b1);
         checks++;
         if (obs() !== 4'b0000) begin
            errors++;
            $display("FAIL reset cycle %0d: outputs %b, expected 0000", i, obs());
         end
      end
      step(1'b0, 1'b0);
   endtask

   task automatic test_long_hold();
      int n_press = 0, n_rel = 0, n_rpt = 0;
      for (int i = 0; i < 34; i++) begin
         step(logic'(i < 30), 1'b0);
         checks++;
         if (obs() !== exp_o) begin
            errors++;
            $display("FAIL long_hold cycle %0d: outputs %b, expected %b", i, obs(), exp_o);
         end
         n_press += int'(bus.press);
         n_rel   += int'(bus.release_evt);
         n_rpt   += int'(bus.repeat_evt);
      end
      checks++;
`ifdef BUTTON_EVENT_REPEAT_EN
      if (n_press != 1 || n_rel != 1 || n_rpt != 5) begin
`else
      if (n_press != 1 || n_rel != 1 || n_rpt != 0) begin
`endif
         errors++;
         $display("FAIL long_hold_counts: press %0d release %0d repeat %0d", n_press, n_rel, n_rpt);
      end
   endtask

   task automatic test_short_press();
      int n_held = 0, n_rpt = 0, rel_at = -1;
      for (int i = 0; i < 9; i++) begin
         step(logic'(i < 5), 1'b0);
         checks++;
         if (obs() !== exp_o) begin
            errors++;
            $display("FAIL short_press cycle %0d: outputs %b, expected %b", i, obs(), exp_o);
         end
         n_held += int'(bus.held);
         n_rpt  += int'(bus.repeat_evt);
         if (bus.release_evt) rel_at = i;
      end
      checks++;
      if (n_held != 5 || n_rpt != 0 || rel_at != 5) begin
         errors++;
         $display("FAIL short_press_shape: held %0d repeat %0d release_at %0d, expected 5 0 5",
                  n_held, n_rpt, rel_at);
      end
   endtask

   task automatic test_release_on_repeat();
      for (int i = 0; i <= 14; i++) begin
         step(logic'(i < 14), 1'b0);
         checks++;
         if (obs() !== exp_o) begin
            errors++;
            $display("FAIL release_on_repeat cycle %0d: outputs %b, expected %b", i, obs(), exp_o);
         end
      end
      checks++;
      if (obs() !== 4'b0100) begin
         errors++;
         $display("FAIL release_wins: outputs %b, expected 0100", obs());
      end
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
   endtask

   task automatic test_reset_mid();
      for (int i = 0; i < 20; i++) begin
         // btn held throughout; reset during cycles P+12..P+13.
         step(1'b1, logic'(i == 12 || i == 13));
         checks++;
         if (obs() !== exp_o) begin
            errors++;
            $display("FAIL reset_mid cycle %0d: outputs %b, expected %b", i, obs(), exp_o);
         end
         if (i == 13) begin
            checks++;
            if (obs() !== 4'b0000) begin
               errors++;
               $display("FAIL reset_mid_quiet: outputs %b, expected 0000", obs());
            end
         end
         if (i == 14) begin
            checks++;
            if (obs() !== 4'b1001) begin
               errors++;
               $display("FAIL press_after_reset: outputs %b, expected 1001", obs());
            end
         end
      end
      step(1'b0, 1'b0);
      step(1'b0, 1'b0);
   endtask

   task automatic test_back_to_back();
      for (int i = 0; i < 10; i++) begin
         step(logic'((i % 2) == 0), 1'b0);
         checks++;
         if (obs() !== exp_o || $countones(obs() & 4'b1110) > 1) begin
            errors++;
            $display("FAIL back_to_back cycle %0d: outputs %b, expected %b", i, obs(), exp_o);
         end
      end
      step(1'b0, 1'b0);
   endtask

   task automatic test_random();
      int run;
      logic b = 1'b0;
      for (int i = 0; i < 800; i++) begin
         if (run == 0) begin
            b   = ~b;
            run = b ? int'($urandom_range(1, 30)) : int'($urandom_range(1, 4));
         end
         run--;
         step(b, logic'($urandom_range(0, 99) == 0));
         checks++;
         if (obs() !== exp_o || $countones(obs() & 4'b1110) > 1) begin
            errors++;
            $display("FAIL random cycle %0d: outputs %b, expected %b", i, obs(), exp_o);
         end
      end
   endtask

   initial begin
      bus.btn = 1'b0;
      rst     = 1'b1;
      test_reset();
      test_long_hold();
      test_short_press();
      test_release_on_repeat();
      test_reset_mid();
      test_back_to_back();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
